// File: rtl/hwpe_stream_strided_load.sv
// Strided TCDM load engine feeding an HWPE-Stream source.
// HWPE_STREAM_STRIDED_LOAD_PERF_EN adds a request-stall counter.
module hwpe_stream_strided_load #(
  parameter int unsigned OUTSTANDING  = 4,
  parameter int unsigned LENGTH_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [31:0]             base_addr_i,
  input  logic [31:0]             stride_i,
  input  logic [LENGTH_WIDTH-1:0] length_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    tcdm_req_o,
  output logic [31:0]             tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [3:0]              tcdm_be_o,
  output logic [31:0]             tcdm_data_o,
  input  logic                    tcdm_gnt_i,
  input  logic [31:0]             tcdm_r_data_i,
  input  logic                    tcdm_r_valid_i,
  output logic                    tcdm_fifo_ready_o,
  output logic                    stream_valid_o,
  output logic [31:0]             stream_data_o,
  output logic [3:0]              stream_strb_o,
  input  logic                    stream_ready_i,
  output logic [31:0]             stall_cycles_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam int unsigned LW = LENGTH_WIDTH;
  localparam logic [4:0] OUT_MAX = 5'(OUTSTANDING);
  localparam logic [LW-1:0] ONE = LW'(1);

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     stride_q, stride_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   issued_q, issued_d;
  logic [4:0]      outst_q, outst_d;
  logic            done_zero_q, done_zero_d;
  logic            drain_done;
  logic            grant;
  logic            resp;

  assign tcdm_req_o = (state_q == RUN) && (issued_q < len_q)
                   && (outst_q < OUT_MAX) && !clear_i;
  assign grant = tcdm_req_o && tcdm_gnt_i;
  assign resp  = tcdm_r_valid_i && (state_q != IDLE);

  assign tcdm_add_o  = addr_q;
  assign tcdm_wen_o  = 1'b1;
  assign tcdm_be_o   = 4'hF;
  assign tcdm_data_o = '0;

  assign tcdm_fifo_ready_o = stream_ready_i;
  assign stream_valid_o    = resp;
  assign stream_data_o     = tcdm_r_data_i;
  assign stream_strb_o     = 4'hF;

  assign busy_o = (state_q != IDLE);
  assign done_o = !clear_i && (done_zero_q || drain_done);

  // Next-state, address walk and issue/outstanding bookkeeping
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    len_d       = len_q;
    issued_d    = issued_q;
    outst_d     = outst_q;
    done_zero_d = 1'b0;
    drain_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d   = base_addr_i;
          stride_d = stride_i;
          len_d    = length_i;
          issued_d = '0;
          if (length_i != '0) state_d = RUN;
          else done_zero_d = 1'b1;
        end
      end
      RUN: begin
        if (grant && (issued_q + ONE == len_q))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (outst_q == '0) begin
          state_d    = IDLE;
          drain_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      issued_d = issued_q + ONE;
      addr_d   = addr_q + stride_q;
    end
    if (grant && !resp) outst_d = outst_q + 5'd1;
    else if (!grant && resp) outst_d = outst_q - 5'd1;
    if (clear_i) begin
      state_d     = IDLE;
      addr_d      = '0;
      stride_d    = '0;
      len_d       = '0;
      issued_d    = '0;
      outst_d     = '0;
      done_zero_d = 1'b0;
    end
  end

  // State and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      outst_q     <= '0;
      done_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      outst_q     <= outst_d;
      done_zero_q <= done_zero_d;
    end
  end

`ifdef HWPE_STREAM_STRIDED_LOAD_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of requests left waiting for a grant
  always_comb begin
    stall_d = stall_q;
    if (clear_i || ((state_q == IDLE) && start_i))
      stall_d = '0;
    else if (tcdm_req_o && !tcdm_gnt_i && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  // Stall counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_hwpe_stream_strided_load.sv
// Directed bench for hwpe_stream_strided_load with a TCDM responder.
// Expected addresses and data (data = address) are hand-derived.
module tb_hwpe_stream_strided_load;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [31:0] stride_i = '0;
  logic [15:0] length_i = '0;
  logic        busy_o, done_o;
  logic        tcdm_req_o, tcdm_wen_o;
  logic [31:0] tcdm_add_o, tcdm_data_o;
  logic [3:0]  tcdm_be_o;
  logic        tcdm_gnt_i = 1'b1;
  logic [31:0] tcdm_r_data_i = '0;
  logic        tcdm_r_valid_i = 1'b0;
  logic        tcdm_fifo_ready_o;
  logic        stream_valid_o;
  logic [31:0] stream_data_o;
  logic [3:0]  stream_strb_o;
  logic        stream_ready_i = 1'b1;
  logic [31:0] stall_cycles_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int sv_cnt = 0;
  int done_cnt = 0;
  bit resp_en = 1'b1;
  int resp_lat = 2;
  logic [31:0] gq[$];
  int          gt[$];
  logic [31:0] glog[$];
  logic [31:0] sq[$];

  hwpe_stream_strided_load #(.OUTSTANDING(4), .LENGTH_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .start_i(start_i), .base_addr_i(base_addr_i),
    .stride_i(stride_i), .length_i(length_i),
    .busy_o(busy_o), .done_o(done_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o),
    .tcdm_data_o(tcdm_data_o), .tcdm_gnt_i(tcdm_gnt_i),
    .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i),
    .tcdm_fifo_ready_o(tcdm_fifo_ready_o),
    .stream_valid_o(stream_valid_o), .stream_data_o(stream_data_o),
    .stream_strb_o(stream_strb_o), .stream_ready_i(stream_ready_i),
    .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  // Record grants, stream beats and done pulses at each active edge
  always @(posedge clk_i) begin
    if (tcdm_req_o && tcdm_gnt_i) begin
      gq.push_back(tcdm_add_o);
      gt.push_back(cyc);
      glog.push_back(tcdm_add_o);
    end
    if (stream_valid_o && stream_ready_i) begin
      sq.push_back(stream_data_o);
      sv_cnt = sv_cnt + 1;
    end
    if (done_o) done_cnt = done_cnt + 1;
    cyc = cyc + 1;
  end

  // Memory responder: returns the address as data after resp_lat cycles
  always @(negedge clk_i) begin
    if (resp_en) begin
      if (gq.size() > 0 && (cyc - gt[0]) >= resp_lat) begin
        tcdm_r_valid_i = 1'b1;
        tcdm_r_data_i  = gq.pop_front();
        gt.delete(0);
      end else begin
        tcdm_r_valid_i = 1'b0;
      end
    end
  end

  task automatic do_start(input logic [31:0] b, input logic [31:0] s,
                          input logic [15:0] l);
    @(negedge clk_i);
    base_addr_i = b;
    stride_i = s;
    length_i = l;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int d = done_cnt;
    int n = 0;
    while (done_cnt == d && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    #1;
    total++;
    if (done_cnt == d) begin
      bad++;
      $display("FAIL %s_timeout done_cnt=%0d required>%0d", nm, done_cnt, d);
    end
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    #1;
    total++;
    if ({busy_o, done_o, tcdm_req_o, stream_valid_o} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outs got=%b required=0000",
               {busy_o, done_o, tcdm_req_o, stream_valid_o});
    end
    total++;
    if (tcdm_add_o !== 32'h0 || stall_cycles_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_regs add=%h stall=%h required=0",
               tcdm_add_o, stall_cycles_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1;
    total++;
    if (busy_o !== 1'b0 || tcdm_wen_o !== 1'b1 || tcdm_be_o !== 4'hF) begin
      bad++;
      $display("FAIL post_reset busy=%b wen=%b be=%h required 0/1/f",
               busy_o, tcdm_wen_o, tcdm_be_o);
    end
  endtask

  task automatic test_basic();
    logic [31:0] e;
    int d0;
    glog.delete();
    sq.delete();
    resp_en = 1'b1;
    resp_lat = 2;
    d0 = done_cnt;
    do_start(32'h1000, 32'd4, 16'd8);
    wait_done("basic");
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy_after got=%b required=0", busy_o);
    end
    total++;
    if (glog.size() != 8 || sq.size() != 8) begin
      bad++;
      $display("FAIL basic_count grants=%0d words=%0d required=8",
               glog.size(), sq.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        e = 32'h1000 + 32'(4 * i);
        total++;
        if (glog[i] !== e || sq[i] !== e) begin
          bad++;
          $display("FAIL basic_word%0d add=%h data=%h required=%h",
                   i, glog[i], sq[i], e);
        end
      end
    end
    repeat (3) @(negedge clk_i);
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL basic_done_pulses got=%0d required=1", done_cnt - d0);
    end
  endtask

  task automatic test_neg_stride();
    logic [31:0] e;
    glog.delete();
    sq.delete();
    do_start(32'h10, 32'hFFFF_FFF8, 16'd4);
    wait_done("negstride");
    total++;
    if (glog.size() != 4 || sq.size() != 4) begin
      bad++;
      $display("FAIL neg_count grants=%0d words=%0d required=4",
               glog.size(), sq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        e = 32'h10 - 32'(8 * i);
        total++;
        if (glog[i] !== e || sq[i] !== e) begin
          bad++;
          $display("FAIL neg_word%0d add=%h data=%h required=%h",
                   i, glog[i], sq[i], e);
        end
      end
    end
  endtask

  task automatic test_outstanding();
    glog.delete();
    sq.delete();
    resp_en = 1'b0;
    tcdm_r_valid_i = 1'b0;
    do_start(32'h2000, 32'd4, 16'd8);
    repeat (10) @(negedge clk_i);
    #1;
    total++;
    if (glog.size() != 4 || tcdm_req_o !== 1'b0) begin
      bad++;
      $display("FAIL outst_cap grants=%0d req=%b required 4/0",
               glog.size(), tcdm_req_o);
    end
    @(negedge clk_i);
    tcdm_r_valid_i = 1'b1;
    tcdm_r_data_i = gq.pop_front();
    gt.delete(0);
    #1;
    total++;
    if (tcdm_req_o !== 1'b0 || stream_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL outst_resp_cycle req=%b sv=%b required 0/1",
               tcdm_req_o, stream_valid_o);
    end
    @(negedge clk_i);
    tcdm_r_valid_i = 1'b0;
    #1;
    total++;
    if (tcdm_req_o !== 1'b1) begin
      bad++;
      $display("FAIL outst_resume req=%b required=1", tcdm_req_o);
    end
    resp_lat = 1;
    resp_en = 1'b1;
    wait_done("outst");
    total++;
    if (sq.size() != 8 || glog.size() != 8) begin
      bad++;
      $display("FAIL outst_words words=%0d grants=%0d required=8",
               sq.size(), glog.size());
    end else begin
      total++;
      if (sq[0] !== 32'h2000 || sq[7] !== 32'h201C) begin
        bad++;
        $display("FAIL outst_order first=%h last=%h required 2000/201c",
                 sq[0], sq[7]);
      end
    end
    resp_lat = 2;
  endtask

  task automatic test_zero_len();
    int d0 = done_cnt;
    glog.delete();
    @(negedge clk_i);
    base_addr_i = 32'h3000;
    stride_i = 32'd4;
    length_i = 16'd0;
    start_i = 1'b1;
    #1;
    total++;
    if (tcdm_req_o !== 1'b0 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL zero_start req=%b done=%b required 0/0",
               tcdm_req_o, done_o);
    end
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    total++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL zero_done done=%b busy=%b required 1/0", done_o, busy_o);
    end
    @(negedge clk_i);
    #1;
    total++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || glog.size() != 0) begin
      bad++;
      $display("FAIL zero_after done=%b busy=%b grants=%0d required 0/0/0",
               done_o, busy_o, glog.size());
    end
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL zero_pulses got=%0d required=1", done_cnt - d0);
    end
  endtask

  task automatic test_clear();
    int n = 0;
    int d0;
    int s0;
    glog.delete();
    sq.delete();
    resp_en = 1'b0;
    tcdm_r_valid_i = 1'b0;
    do_start(32'h4000, 32'd4, 16'd8);
    while (glog.size() < 3 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    d0 = done_cnt;
    s0 = sv_cnt;
    total++;
    if (glog.size() != 3) begin
      bad++;
      $display("FAIL clear_grants got=%0d required=3", glog.size());
    end
    for (int i = 0; i < 2; i++) begin
      tcdm_r_valid_i = 1'b1;
      tcdm_r_data_i = gq.pop_front();
      gt.delete(0);
      #1;
      total++;
      if (stream_valid_o !== 1'b0 || busy_o !== 1'b0) begin
        bad++;
        $display("FAIL clear_late%0d sv=%b busy=%b required 0/0",
                 i, stream_valid_o, busy_o);
      end
      @(negedge clk_i);
    end
    tcdm_r_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    total++;
    if (sv_cnt != s0 || done_cnt != d0 || tcdm_req_o !== 1'b0) begin
      bad++;
      $display("FAIL clear_quiet sv=%0d done=%0d req=%b required none",
               sv_cnt - s0, done_cnt - d0, tcdm_req_o);
    end
    gq.delete();
    gt.delete();
    glog.delete();
    sq.delete();
    resp_en = 1'b1;
    do_start(32'h5000, 32'd8, 16'd4);
    wait_done("clear_restart");
    total++;
    if (sq.size() != 4) begin
      bad++;
      $display("FAIL clear_restart_count got=%0d required=4", sq.size());
    end else begin
      total++;
      if (sq[0] !== 32'h5000 || sq[3] !== 32'h5018) begin
        bad++;
        $display("FAIL clear_restart_data first=%h last=%h required 5000/5018",
                 sq[0], sq[3]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] e;
`ifdef HWPE_STREAM_STRIDED_LOAD_PERF_EN
    e = 32'd5;
`else
    e = 32'd0;
`endif
    sq.delete();
    tcdm_gnt_i = 1'b0;
    do_start(32'h6000, 32'd4, 16'd2);
    #1;
    total++;
    if (tcdm_req_o !== 1'b1) begin
      bad++;
      $display("FAIL stall_req got=%b required=1", tcdm_req_o);
    end
    repeat (5) @(negedge clk_i);
    tcdm_gnt_i = 1'b1;
    wait_done("stall");
    total++;
    if (stall_cycles_o !== e) begin
      bad++;
      $display("FAIL stall_count got=%0d required=%0d", stall_cycles_o, e);
    end
    total++;
    if (sq.size() != 2) begin
      bad++;
      $display("FAIL stall_words got=%0d required=2", sq.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_neg_stride();
    test_outstanding();
    test_zero_len();
    test_clear();
    test_stall();
    repeat (2) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_strided_load.md
HWPE_STREAM_STRIDED_LOAD -- requirements
Module: hwpe_stream_strided_load

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 4: maximum loads granted but not yet returned (1..16).
REQ-002 SHALL have parameter LENGTH_WIDTH, default 16: width of the transfer word count.
REQ-003 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear_i  input  1  synchronous clear.
REQ-006 SHALL have port start_i  input  1  one-cycle launch pulse.
REQ-007 SHALL have port base_addr_i  input  32  byte address of the first word.
REQ-008 SHALL have port stride_i  input  32  signed byte stride between words.
REQ-009 SHALL have port length_i  input  LENGTH_WIDTH  number of words to load.
REQ-010 SHALL have port busy_o  output  1  high when not IDLE.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse at transfer completion.
REQ-012 SHALL have port tcdm_req_o, tcdm_add_o(32), tcdm_wen_o, tcdm_be_o(4), tcdm_data_o(32)  output  TCDM load master request side.
REQ-013 SHALL have port tcdm_gnt_i  input  1  and  tcdm_r_data_i  input  32  and  tcdm_r_valid_i  input  1  as the TCDM response side; this port drives the slave side of the TCDM load FIFO.
REQ-014 SHALL have port tcdm_fifo_ready_o  output  1  backpressure to the load FIFO ready_i.
REQ-015 SHALL have port stream_valid_o, stream_data_o(32), stream_strb_o(4)  output  and  stream_ready_i  input  as an HWPE-Stream source.
REQ-016 SHALL have port stall_cycles_o  output  32  request-stall counter (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-018 In IDLE, start_i SHALL latch the address (base_addr_i), word count (length_i), stride, and reset the issue count; next state is RUN if length_i != 0, otherwise remain IDLE and pulse done_o in the following cycle.
REQ-019 In RUN, tcdm_req_o SHALL equal (issued < length) AND (outstanding < OUTSTANDING); wen=1, be=4'hF, data=0 constant.
REQ-020 On req&gnt, the block SHALL increment issued, increment outstanding, and advance the address by stride modulo 2^32 in the same edge.
REQ-021 tcdm_add_o SHALL hold stable while req is high and gnt is low.
REQ-022 When the final word is granted, the next state SHALL be DRAIN.
REQ-023 In DRAIN, when outstanding==0, the block SHALL return to IDLE with done_o=1 for exactly that one cycle.
REQ-024 stream_valid_o SHALL equal tcdm_r_valid_i when the state is not IDLE, and 0 in IDLE; stream_data_o=tcdm_r_data_i; stream_strb_o=4'hF; latency from response to stream is 0 cycles.
REQ-025 tcdm_fifo_ready_o SHALL equal stream_ready_i; an r_valid is delivered only while stream_ready_i=1, so no local buffering is needed.
REQ-026 outstanding SHALL decrement on each r_valid accepted outside IDLE; a simultaneous grant and response SHALL leave it unchanged.
REQ-027 start_i while busy_o=1 SHALL be ignored.
REQ-028 clear_i SHALL force IDLE, zero all counters, deassert req, and suppress done_o; r_valid arriving after clear SHALL be dropped.
REQ-029 Word count and response order SHALL be preserved: exactly length words are emitted in address order.

Reset
REQ-030 While rst_ni=0: state=IDLE; busy_o, done_o, tcdm_req_o, stream_valid_o=0; address, issued, outstanding and stall_cycles_o=0.
REQ-031 Deassertion of reset SHALL take effect at the first rising edge of clk_i with no extra cycles.

Configuration
REQ-032 Macro HWPE_STREAM_STRIDED_LOAD_PERF_EN defined: stall_cycles_o SHALL count cycles with tcdm_req_o=1 and tcdm_gnt_i=0, saturating at 2^32-1, zeroed on start_i accepted or clear_i.
REQ-033 Macro undefined: stall_cycles_o SHALL be tied to 0 and no counter flops SHALL be inferred.

Verification
REQ-034 base=0x1000, stride=4, length=8, gnt=1 always, 2-cycle response, ready=1 -> addresses 0x1000..0x101C issued, 8 stream words in order, done_o one pulse, busy_o low next cycle.
REQ-035 stride=0xFFFFFFF8 (-8), base=0x10, length=4 -> addresses 0x10, 0x08, 0x00, 0xFFFFFFF8.
REQ-036 OUTSTANDING=4, responses withheld -> exactly 4 grants then req=0 until the first r_valid, then req resumes the next cycle.
REQ-037 length=0 start -> no req, done_o high one cycle later, busy_o stays 0.
REQ-038 clear_i mid-RUN after 3 of 8 grants, then 2 late r_valid -> state IDLE, no stream_valid_o, no done_o; new start runs cleanly.
REQ-039 PERF_EN defined, gnt low for 5 cycles while req high -> stall_cycles_o=5; undefined -> stall_cycles_o=0.
